sync_debounce: RTL and testbench

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

---
 rtl/sync_pkg.sv | 24 ++
 rtl/sync_debounce_ch.sv | 73 +++++++
 rtl/sync_debounce.sv | 40 ++++
 tb/tb_sync_debounce.sv | 110 +++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// sync_pkg: shared constants and helpers for the synchroniser/debouncer
package sync_pkg;

    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 32;
    localparam int STAGES_MIN   = 2;
    localparam int STAGES_MAX   = 4;
    localparam int DEBOUNCE_MAX = 65535;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2w(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) w++;
        return w;
    endfunction

    function automatic bit params_ok(input int channels, input int stages, input int debounce);
        return channels >= CHANNELS_MIN && channels <= CHANNELS_MAX &&
               stages >= STAGES_MIN && stages <= STAGES_MAX &&
               debounce >= 0 && debounce <= DEBOUNCE_MAX;
    endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// sync_debounce_ch: one channel of flop synchroniser, optional debounce filter and edge pulses
module sync_debounce_ch
    import sync_pkg::*;
#(
    parameter int   STAGES       = 2,
    parameter int   DEBOUNCE_CNT = 4,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sh;
    logic              q_next;

    // Synchroniser chain; shifts only on enabled edges.
    always_ff @(posedge clk) begin
        if (rst) sh <= {STAGES{RESET_VAL}};
        else if (en) sh <= {sh[STAGES-2:0], d};
    end

    generate
        if (DEBOUNCE_CNT == 0) begin : g_bypass
            assign q      = sh[STAGES-1];
            assign q_next = en ? sh[STAGES-2] : sh[STAGES-1];
        end else begin : g_filter
            localparam int            CW   = clog2w(DEBOUNCE_CNT + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);
            logic [CW-1:0] cnt, cnt_next;
            logic          q_r;
            // Count consecutive enabled mismatches; accept the new level when the count reaches the limit.
            always_comb begin
                cnt_next = cnt;
                q_next   = q_r;
                if (en) begin
                    if (sh[STAGES-1] == q_r) cnt_next = '0;
                    else if (cnt == LAST) begin
                        cnt_next = '0;
                        q_next   = sh[STAGES-1];
                    end else cnt_next = cnt + CW'(1);
                end
            end
            // Filter state register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt <= '0;
                    q_r <= RESET_VAL;
                end else begin
                    cnt <= cnt_next;
                    q_r <= q_next;
                end
            end
            assign q = q_r;
        end
    endgenerate

    // Edge pulses land together with the output change and drop on the following edge, enabled or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= q_next & ~q;
            fall <= q & ~q_next;
        end
    end

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: multi-channel synchroniser and debouncer with rise/fall pulse outputs
module sync_debounce
    import sync_pkg::*;
#(
    parameter int                  CHANNELS     = 8,
    parameter int                  STAGES       = 2,
    parameter int                  DEBOUNCE_CNT = 4,
    parameter logic [CHANNELS-1:0] RESET_VAL    = '0
) (
    input  logic                sync_clk,
    input  logic                sync_rst,
    input  logic                sync_clk_en,
    input  logic [CHANNELS-1:0] data_in,
    output logic [CHANNELS-1:0] data_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);

    generate
        if (!params_ok(CHANNELS, STAGES, DEBOUNCE_CNT)) begin : g_bad_params
            $error("sync_debounce: parameter out of range");
        end
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            sync_debounce_ch #(
                .STAGES       (STAGES),
                .DEBOUNCE_CNT (DEBOUNCE_CNT),
                .RESET_VAL    (RESET_VAL[i])
            ) u_ch (
                .clk  (sync_clk),
                .rst  (sync_rst),
                .en   (sync_clk_en),
                .d    (data_in[i]),
                .q    (data_out[i]),
                .rise (rise_pulse[i]),
                .fall (fall_pulse[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: directed scoreboard bench for a filtered and a bypass configuration
module tb_sync_debounce;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] din_a, din_b;
    logic [7:0] out_a, rise_a, fall_a;
    logic [7:0] out_b, rise_b, fall_b;
    int         checks = 0;
    int         errors = 0;
    string      tag_q[$];
    logic [24:0] exp_q[$];

    always #5 clk = ~clk;

    sync_debounce #(.CHANNELS(8), .STAGES(2), .DEBOUNCE_CNT(4), .RESET_VAL(8'h00)) dut_a (
        .sync_clk(clk), .sync_rst(rst), .sync_clk_en(en), .data_in(din_a),
        .data_out(out_a), .rise_pulse(rise_a), .fall_pulse(fall_a)
    );

    sync_debounce #(.CHANNELS(8), .STAGES(3), .DEBOUNCE_CNT(0), .RESET_VAL(8'hF0)) dut_b (
        .sync_clk(clk), .sync_rst(rst), .sync_clk_en(en), .data_in(din_b),
        .data_out(out_b), .rise_pulse(rise_b), .fall_pulse(fall_b)
    );

    task automatic ea(input string t, input logic [7:0] d, input logic [7:0] r, input logic [7:0] f);
        tag_q.push_back(t);
        exp_q.push_back({1'b0, d, r, f});
    endtask

    task automatic eb(input string t, input logic [7:0] d, input logic [7:0] r, input logic [7:0] f);
        tag_q.push_back(t);
        exp_q.push_back({1'b1, d, r, f});
    endtask

    task automatic tick();
        string       t;
        logic [24:0] e;
        logic [23:0] obs;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            obs = e[24] ? {out_b, rise_b, fall_b} : {out_a, rise_a, fall_a};
            checks++;
            assert (obs === e[23:0]) else begin
                errors++;
                $error("FAIL %s: out/rise/fall got %h/%h/%h expected %h/%h/%h",
                       t, obs[23:16], obs[15:8], obs[7:0], e[23:16], e[15:8], e[7:0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; din_a = 8'h00; din_b = 8'hF0;
        tick(); tick();
        ea("reset_a", 8'h00, 8'h00, 8'h00);
        eb("reset_b", 8'hF0, 8'h00, 8'h00);
        tick();
        rst = 1'b0; din_a = 8'hFF;
        for (int k = 0; k < 5; k++) begin ea("rise_wait", 8'h00, 8'h00, 8'h00); tick(); end
        ea("rise_edge6", 8'hFF, 8'hFF, 8'h00); tick();
        ea("rise_clear", 8'hFF, 8'h00, 8'h00); tick();
        din_a = 8'h00;
        for (int k = 0; k < 5; k++) begin ea("fall_wait", 8'hFF, 8'h00, 8'h00); tick(); end
        ea("fall_edge6", 8'h00, 8'h00, 8'hFF); tick();
        ea("fall_clear", 8'h00, 8'h00, 8'h00); tick();
        din_a = 8'h01;
        for (int k = 0; k < 3; k++) begin ea("glitch_hi", 8'h00, 8'h00, 8'h00); tick(); end
        din_a = 8'h00;
        for (int k = 0; k < 6; k++) begin ea("glitch_lo", 8'h00, 8'h00, 8'h00); tick(); end
        din_a = 8'h01;
        for (int k = 0; k < 10; k++) begin
            en = (k % 2 == 0);
            ea("en_wait", 8'h00, 8'h00, 8'h00); tick();
        end
        en = 1'b1; ea("en_edge6", 8'h01, 8'h01, 8'h00); tick();
        en = 1'b0; ea("en_clear", 8'h01, 8'h00, 8'h00); tick();
        en = 1'b1; din_a = 8'h03;
        for (int k = 0; k < 5; k++) begin ea("pre_rst", 8'h01, 8'h00, 8'h00); tick(); end
        rst = 1'b1; en = 1'b0;
        ea("rst_mid", 8'h00, 8'h00, 8'h00); tick();
        ea("rst_hold", 8'h00, 8'h00, 8'h00); tick();
        rst = 1'b0; en = 1'b1; din_a = 8'h02;
        for (int k = 0; k < 5; k++) begin ea("post_rst", 8'h00, 8'h00, 8'h00); tick(); end
        ea("post_rst_edge6", 8'h02, 8'h02, 8'h00); tick();
        din_a = 8'h01;
        for (int k = 0; k < 5; k++) begin ea("simul_wait", 8'h02, 8'h00, 8'h00); tick(); end
        ea("simul_edge6", 8'h01, 8'h01, 8'h02); tick();
        ea("simul_clear", 8'h01, 8'h00, 8'h00); tick();
        din_b = 8'h0F;
        for (int k = 0; k < 2; k++) begin eb("b_wait", 8'hF0, 8'h00, 8'h00); tick(); end
        eb("b_edge3", 8'h0F, 8'h0F, 8'hF0); tick();
        eb("b_clear", 8'h0F, 8'h00, 8'h00); tick();
        din_b = 8'h0E;
        for (int k = 0; k < 2; k++) begin eb("b_fall_wait", 8'h0F, 8'h00, 8'h00); tick(); end
        eb("b_fall", 8'h0E, 8'h00, 8'h01); tick();
        eb("b_fall_clear", 8'h0E, 8'h00, 8'h00); tick();
        en = 1'b0; din_b = 8'h0F;
        for (int k = 0; k < 3; k++) begin eb("b_hold", 8'h0E, 8'h00, 8'h00); tick(); end
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin eb("b_rise_wait", 8'h0E, 8'h00, 8'h00); tick(); end
        eb("b_rise", 8'h0F, 8'h01, 8'h00); tick();
        eb("b_rise_clear", 8'h0F, 8'h00, 8'h00); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
